mult_4x4_seq: RTL and testbench



---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_shift_add_core.sv | 82 ++++++++
 rtl/mult_4x4_seq.sv | 71 +++++++
 tb/tb_mult_4x4_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the sequential 4x4 multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/mult_shift_add_core.sv
// Iterative shift-add unsigned multiplier: one partial product per clock.
module mult_shift_add_core
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH) + 1;

  state_e            r_state, w_state_d;
  logic [ProdW-1:0]  r_acc, w_acc_d;
  logic [ProdW-1:0]  r_mcand, w_mcand_d;
  logic [WIDTH-1:0]  r_mplier, w_mplier_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_cnt    <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_cnt_d    = r_cnt;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_acc_d    = '0;
          w_mcand_d  = {{WIDTH{1'b0}}, a};
          w_mplier_d = b;
          w_cnt_d    = '0;
          w_state_d  = CALC;
        end
      end
      CALC: begin
        if (r_mplier[0]) begin
          w_acc_d = r_acc + r_mcand;
        end
        w_mcand_d  = r_mcand << 1;
        w_mplier_d = r_mplier >> 1;
        w_cnt_d    = r_cnt + 1'b1;
        if (r_cnt == CntW'(WIDTH - 1)) begin
          w_state_d = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign product = r_acc;

endmodule

// File: rtl/mult_4x4_seq.sv
// Board-level multiplier: synchronises switch/key operands, runs the shift-add core,
// and registers the product onto the LED bank.
module mult_4x4_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     sw,
  input  logic [WIDTH-1:0]     key,
  output logic [2*WIDTH-1:0]   led
);

  localparam int unsigned ProdW = 2 * WIDTH;

  logic [WIDTH-1:0] r_sw_meta, r_sw_sync;
  logic [WIDTH-1:0] r_key_meta, r_key_sync;
  logic [WIDTH-1:0] r_a_c, r_b_c;
  logic [ProdW-1:0] r_led;

  logic [WIDTH-1:0] w_a_s, w_b_s;
  logic             w_start, w_busy, w_done;
  logic [ProdW-1:0] w_product;

  assign w_a_s = r_sw_sync;
  assign w_b_s = ~r_key_sync;
  // Only restart once the core is back in IDLE so an in-flight product always completes.
  assign w_start = !w_busy && ({w_a_s, w_b_s} != {r_a_c, r_b_c});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_key_meta <= '1;
      r_key_sync <= '1;
      r_a_c      <= '0;
      r_b_c      <= '0;
      r_led      <= {ProdW{LED_ACTIVE_LOW}};
    end else begin
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
      r_key_meta <= key;
      r_key_sync <= r_key_meta;
      if (w_start) begin
        r_a_c <= w_a_s;
        r_b_c <= w_b_s;
      end
      if (w_done) begin
        r_led <= LED_ACTIVE_LOW ? ~w_product : w_product;
      end
    end
  end

  mult_shift_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .a       (w_a_s),
    .b       (w_b_s),
    .busy    (w_busy),
    .done    (w_done),
    .product (w_product)
  );

  assign led = r_led;

endmodule

// File: tb/tb_mult_4x4_seq.sv
// Directed bench for mult_4x4_seq: active-high and active-low LED instances share stimulus.
module tb_mult_4x4_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] key;
  logic [7:0] led;
  logic [7:0] led_al;

  int n_tests = 0;
  int n_fail  = 0;

  mult_4x4_seq #(
    .WIDTH          (4),
    .LED_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .key   (key),
    .led   (led)
  );

  mult_4x4_seq #(
    .WIDTH          (4),
    .LED_ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .key   (key),
    .led   (led_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected 10*k for k = 1..15, worked by hand.
  logic [7:0] sweep_exp [15] = '{8'h0A, 8'h14, 8'h1E, 8'h28, 8'h32, 8'h3C, 8'h46, 8'h50,
                                 8'h5A, 8'h64, 8'h6E, 8'h78, 8'h82, 8'h8C, 8'h96};

  initial begin
    logic [7:0] prev;
    logic [3:0] kv;

    // Reset with A=10, B=15 applied
    rst_n = 1'b0;
    sw    = 4'hA;
    key   = 4'h0;
    cycles(3);
    check_eq("reset_led", led, 8'h00);
    check_eq("reset_led_al", led_al, 8'hFF);
    rst_n = 1'b1;
    cycles(9);
    check_eq("post_reset_10x15", led, 8'h96);
    check_eq("post_reset_10x15_al", led_al, 8'h69);

    // Sweep B = 1..15 with A = 10
    for (int k = 1; k <= 15; k++) begin
      kv  = 4'(k);
      key = ~kv;
      cycles(10);
      check_eq($sformatf("sweep_b%0d", k), led, sweep_exp[k-1]);
      if (k == 1) check_eq("active_low_10x1", led_al, 8'hF5);
    end

    // Extremes
    sw = 4'hF; key = 4'h0; cycles(10);
    check_eq("max_15x15", led, 8'hE1);
    sw = 4'h0; key = 4'h0; cycles(10);
    check_eq("a_zero", led, 8'h00);
    sw = 4'hF; key = 4'hF; cycles(10);
    check_eq("b_zero", led, 8'h00);
    check_eq("led_holds", led, 8'h00);

    // Operand change two cycles into CALC: 3*5 must finish, then 3*7
    prev = led;
    sw   = 4'h3;
    key  = ~4'd5;
    cycles(5);
    key  = ~4'd7;
    for (int i = 0; i < 9 && led == prev; i++) cycles(1);
    check_eq("midcalc_first_3x5", led, 8'h0F);
    prev = led;
    for (int i = 0; i < 9 && led == prev; i++) cycles(1);
    check_eq("midcalc_second_3x7", led, 8'h15);

    // Asynchronous reset in the middle of CALC
    sw  = 4'h2;
    key = ~4'd4;
    cycles(4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_led", led, 8'h00);
    check_eq("async_reset_led_al", led_al, 8'hFF);
    cycles(2);
    rst_n = 1'b1;
    cycles(9);
    check_eq("after_reset_2x4", led, 8'h08);
    check_eq("after_reset_2x4_al", led_al, 8'hF7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
